// File: rtl/note_track_scroller_if.sv
// ---------------------------------------------------------------------------
// note_track_scroller_if
//   Read port of the external synchronous chart ROM. The scroller drives the
//   strobe and address; the ROM answers with one 2-bit symbol the cycle after
//   each strobe.
// Signals
//   rd_en    chart ROM read strobe            (master -> slave)
//   rd_addr  chart ROM address, ADDR_W bits   (master -> slave)
//   rd_data  symbol, valid cycle after rd_en  (slave -> master)
// Modports
//   master   the scroller
//   slave    the chart ROM
// ---------------------------------------------------------------------------
interface note_track_scroller_if #(
  parameter int ADDR_W = 10
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/note_track_scroller.sv
// ---------------------------------------------------------------------------
// note_track_scroller
//   Streams a note chart (one 2-bit symbol per ROM address) into a WIN-symbol
//   sliding window, scrolls it one symbol every SUB_STEPS sub-steps of
//   TICK_CYCLES clocks, and decodes the window to per-lane R/G/B drive.
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start              begin a song (only looked at while idle)
//   song_base/len      first chart address and symbol count, latched on start
//   loop               restart the song instead of finishing
//   pause              freeze the scroll timing
//   abort              return to idle at once, no done pulse
//   chart              chart ROM read port (master side)
//   note_R/G/B         lane colours, bit 0 nearest the hit line
//   offset             current sub-step
//   index              chart symbol currently at window position 0
//   busy, done         busy outside IDLE, done pulses once at end of song
// ---------------------------------------------------------------------------
module note_track_scroller #(
  parameter int WIN         = 10,
  parameter int SUB_STEPS   = 7,
  parameter int TICK_CYCLES = 100000,
  parameter int ADDR_W      = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            song_base,
  input  logic [ADDR_W-1:0]            song_len,
  input  logic                         loop,
  input  logic                         pause,
  input  logic                         abort,
  note_track_scroller_if.master        chart,
  output logic [WIN-1:0]               note_R,
  output logic [WIN-1:0]               note_G,
  output logic [WIN-1:0]               note_B,
  output logic [$clog2(SUB_STEPS)-1:0] offset,
  output logic [ADDR_W-1:0]            index,
  output logic                         busy,
  output logic                         done
);

  localparam int OFF_W  = $clog2(SUB_STEPS);
  localparam int TICK_W = $clog2(TICK_CYCLES);
  localparam int PC_W   = $clog2(WIN + 2);
  // Wide enough that index+WIN never wraps before the song_len comparison.
  localparam int CW     = ADDR_W + $clog2(WIN + 1) + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(SUB_STEPS - 1);
  localparam logic [PC_W-1:0]   PC_LAST   = PC_W'(WIN + 1);

  typedef enum logic [1:0] {IDLE, PRELOAD, RUN, FINISH} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   len_q;
  logic [TICK_W-1:0]   tick_q;
  logic [PC_W-1:0]     pcnt_q;
  logic [WIN-1:0][1:0] win_q;
  logic [1:0]          hold_q;
  logic                pf_issue_q;
  logic                pf_cap_q;
  logic                rd_issued_q;

  logic                tick_wrap;
  logic                sym_step;
  logic                song_end;
  logic [ADDR_W-1:0]   next_index;
  logic                rd_req;
  logic [CW-1:0]       rd_pos;
  logic [1:0]          cap_val;

  // Scroll timing events. A symbol step is the sub-step wrap that also wraps
  // the offset; song_end is the step that moves index onto song_len.
  // cap_val is what lands this cycle: ROM data if a read was issued last
  // cycle, otherwise a blank for positions past the end of the chart.
  always_comb begin
    tick_wrap  = (tick_q == TICK_LAST);
    sym_step   = (state_q == RUN) && !pause && tick_wrap && (offset == OFF_LAST);
    next_index = index + ADDR_W'(1);
    song_end   = sym_step && (next_index == len_q);
    cap_val    = rd_issued_q ? chart.rd_data : 2'b00;
  end

  // Read request: PRELOAD walks window positions 0..WIN (WIN being the hold
  // register), RUN issues one prefetch of position WIN after each step.
  // Positions at or beyond song_len are never read.
  always_comb begin
    rd_req = 1'b0;
    rd_pos = CW'(index) + CW'(WIN);
    if ((state_q == PRELOAD) && (pcnt_q <= PC_W'(WIN))) begin
      rd_req = 1'b1;
      rd_pos = CW'(index) + CW'(pcnt_q);
    end else if ((state_q == RUN) && pf_issue_q) begin
      rd_req = 1'b1;
    end
    chart.rd_en   = rd_req && !abort && (rd_pos < CW'(len_q));
    chart.rd_addr = chart.rd_en ? (base_q + rd_pos[ADDR_W-1:0]) : '0;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = (state_q == FINISH);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (song_len == '0) ? FINISH : PRELOAD;
        end
      end
      PRELOAD: begin
        if (pcnt_q == PC_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (song_end) begin
          state_d = loop ? PRELOAD : FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  // Datapath: song latches, tick/offset/index counters, window and hold
  // register. PRELOAD captures each symbol one cycle after its read, so slot
  // k is written while pcnt_q == k+1 and the hold register at pcnt_q == WIN+1.
  // A step shifts the window toward position 0 and arms a prefetch for the
  // new tail symbol, which is captured into hold two cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q      <= '0;
      len_q       <= '0;
      tick_q      <= '0;
      offset      <= '0;
      index       <= '0;
      pcnt_q      <= '0;
      win_q       <= '0;
      hold_q      <= '0;
      pf_issue_q  <= 1'b0;
      pf_cap_q    <= 1'b0;
      rd_issued_q <= 1'b0;
    end else if (abort) begin
      tick_q      <= '0;
      offset      <= '0;
      index       <= '0;
      pcnt_q      <= '0;
      win_q       <= '0;
      hold_q      <= '0;
      pf_issue_q  <= 1'b0;
      pf_cap_q    <= 1'b0;
      rd_issued_q <= 1'b0;
    end else begin
      rd_issued_q <= chart.rd_en;
      pf_issue_q  <= 1'b0;
      pf_cap_q    <= pf_issue_q;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q <= song_base;
            len_q  <= song_len;
            tick_q <= '0;
            offset <= '0;
            index  <= '0;
            pcnt_q <= '0;
          end
        end
        PRELOAD: begin
          for (int k = 0; k < WIN; k++) begin
            if (pcnt_q == PC_W'(k + 1)) begin
              win_q[k] <= cap_val;
            end
          end
          if (pcnt_q == PC_LAST) begin
            hold_q <= cap_val;
            pcnt_q <= '0;
            tick_q <= '0;
            offset <= '0;
          end else begin
            pcnt_q <= pcnt_q + PC_W'(1);
          end
        end
        RUN: begin
          if (pf_cap_q) begin
            hold_q <= cap_val;
          end
          if (!pause) begin
            if (!tick_wrap) begin
              tick_q <= tick_q + TICK_W'(1);
            end else begin
              tick_q <= '0;
              if (offset != OFF_LAST) begin
                offset <= offset + OFF_W'(1);
              end else begin
                offset <= '0;
                index  <= next_index;
                win_q  <= {hold_q, win_q[WIN-1:1]};
                if (!song_end) begin
                  pf_issue_q <= 1'b1;
                end else if (loop) begin
                  index  <= '0;
                  pcnt_q <= '0;
                end else begin
                  win_q  <= '0;
                  hold_q <= '0;
                end
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered colour decode: 01 red, 10 blue, 11 green, 00 dark.
  // Abort darkens the lanes on the very next cycle rather than one later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_R <= '0;
      note_G <= '0;
      note_B <= '0;
    end else if (abort) begin
      note_R <= '0;
      note_G <= '0;
      note_B <= '0;
    end else begin
      for (int k = 0; k < WIN; k++) begin
        note_R[k] <= (win_q[k] == 2'b01);
        note_G[k] <= (win_q[k] == 2'b11);
        note_B[k] <= (win_q[k] == 2'b10);
      end
    end
  end

endmodule
